// File: rtl/demux_pkg.sv
// Shared widths and enums for the 32-bit 1-to-2 word demultiplexer.
package demux_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } channel_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot with load/drain handshake; optional drain counter
// when DEMUX_CNT_EN is defined.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
`ifdef DEMUX_CNT_EN
  , parameter int unsigned CNT_W = CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ok_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0] cnt
`endif
);

  slot_state_e      state, state_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             drain_c;

  assign drain_c   = (state == SLOT_FULL) && out_ready;
  // A slot that empties this edge can take a new word on the same edge.
  assign load_ok_c = (state == SLOT_EMPTY) || drain_c;
  assign out_valid = (state == SLOT_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SLOT_EMPTY;
      out_data <= '0;
    end else begin
      state    <= state_nxt;
      out_data <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = out_data;
    case (state)
      SLOT_EMPTY: begin
        if (load) begin
          state_nxt = SLOT_FULL;
          data_nxt  = load_data;
        end
      end
      SLOT_FULL: begin
        if (load) begin
          data_nxt = load_data;
        end else if (drain_c) begin
          state_nxt = SLOT_EMPTY;
        end
      end
      default: state_nxt = SLOT_EMPTY;
    endcase
  end

`ifdef DEMUX_CNT_EN
  // Delivered-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (drain_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/demux32_1to2_buf.sv
// Registered 1-to-2 word demultiplexer: steers a producer word into slot A or B.
// Optional per-output delivery counters with DEMUX_CNT_EN.
module demux32_1to2_buf
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
`ifdef DEMUX_CNT_EN
  , parameter int unsigned CNT_W = CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             select,
  input  logic [WIDTH-1:0] in_data,
  output logic             outA_valid,
  input  logic             outA_ready,
  output logic [WIDTH-1:0] outA_data,
  output logic             outB_valid,
  input  logic             outB_ready,
  output logic [WIDTH-1:0] outB_data
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0] cntA
  , output logic [CNT_W-1:0] cntB
`endif
);

  channel_e ch;
  logic     ok_a, ok_b;
  logic     load_a, load_b;

  // in_ready only looks at the selected slot, so a stalled B never blocks A.
  assign ch       = channel_e'(select);
  assign in_ready = (ch == CH_B) ? ok_b : ok_a;
  assign load_a   = in_valid && in_ready && (ch == CH_A);
  assign load_b   = in_valid && in_ready && (ch == CH_B);

  demux_slot #(
    .WIDTH (WIDTH)
`ifdef DEMUX_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) u_slot_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_a),
    .load_data (in_data),
    .load_ok_c (ok_a),
    .out_valid (outA_valid),
    .out_ready (outA_ready),
    .out_data  (outA_data)
`ifdef DEMUX_CNT_EN
    , .cnt     (cntA)
`endif
  );

  demux_slot #(
    .WIDTH (WIDTH)
`ifdef DEMUX_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) u_slot_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_b),
    .load_data (in_data),
    .load_ok_c (ok_b),
    .out_valid (outB_valid),
    .out_ready (outB_ready),
    .out_data  (outB_data)
`ifdef DEMUX_CNT_EN
    , .cnt     (cntB)
`endif
  );

endmodule

// File: tb/tb_demux32_1to2_buf.sv
// Self-checking bench for demux32_1to2_buf: directed steps plus randomized traffic
// against a queue-based reference model.
module tb_demux32_1to2_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, select;
  logic [31:0] in_data;
  logic        outA_valid, outA_ready, outB_valid, outB_ready;
  logic [31:0] outA_data, outB_data;
`ifdef DEMUX_CNT_EN
  logic [15:0] cntA, cntB;
`endif

  always #5 clk = ~clk;

  demux32_1to2_buf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .select     (select),
    .in_data    (in_data),
    .outA_valid (outA_valid),
    .outA_ready (outA_ready),
    .outA_data  (outA_data),
    .outB_valid (outB_valid),
    .outB_ready (outB_ready),
    .outB_data  (outB_data)
`ifdef DEMUX_CNT_EN
    , .cntA     (cntA)
    , .cntB     (cntB)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: each output is a FIFO of at most one pending word.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int unsigned exp_cnt_a = 0;
  int unsigned exp_cnt_b = 0;
  bit          last_accept;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit sel, input logic [31:0] d,
                       input bit ra, input bit rb);
    in_valid   = v;
    select     = sel;
    in_data    = d;
    outA_ready = ra;
    outB_ready = rb;
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    exp_cnt_a = 0;
    exp_cnt_b = 0;
  endtask

  function automatic bit model_ready();
    if (select) return (qb.size() == 0) || outB_ready;
    return (qa.size() == 0) || outA_ready;
  endfunction

  task automatic check_outputs();
    check("outA_valid", 32'(outA_valid), 32'(qa.size() != 0));
    check("outB_valid", 32'(outB_valid), 32'(qb.size() != 0));
    if (qa.size() != 0) check("outA_data", outA_data, qa[0]);
    if (qb.size() != 0) check("outB_data", outB_data, qb[0]);
`ifdef DEMUX_CNT_EN
    check("cntA", 32'(cntA), exp_cnt_a & 32'hFFFF);
    check("cntB", 32'(cntB), exp_cnt_b & 32'hFFFF);
`endif
  endtask

  // One clock: check in_ready against the model, advance the model, check outputs.
  task automatic step();
    bit rdy;
    #1;
    rdy = model_ready();
    check("in_ready", 32'(in_ready), 32'(rdy));
    last_accept = in_valid && rdy;
    if (qa.size() != 0 && outA_ready) begin void'(qa.pop_front()); exp_cnt_a++; end
    if (qb.size() != 0 && outB_ready) begin void'(qb.pop_front()); exp_cnt_b++; end
    if (last_accept) begin
      if (select) qb.push_back(in_data);
      else        qa.push_back(in_data);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    bit          pend_v;
    bit          pend_s;
    logic [31:0] pend_d;

    // Power-on reset
    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 0);
    #12;
    check("reset_outA_valid", 32'(outA_valid), 32'h0);
    check("reset_outB_valid", 32'(outB_valid), 32'h0);
    check("reset_outA_data", outA_data, 32'h0);
    check("reset_outB_data", outB_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Steering
    drive(1, 0, 32'h11111111, 1, 1); step();
    check("steer_A", outA_data, 32'h11111111);
    drive(1, 1, 32'h22222222, 1, 1); step();
    check("steer_B", outB_data, 32'h22222222);
    drive(0, 0, 32'h0, 1, 1); step();

    // Independent backpressure
    drive(1, 1, 32'hB0, 1, 0); step();
    drive(1, 0, 32'hA0, 1, 0); step();
    check("bp_A_data", outA_data, 32'hA0);
    check("bp_B_valid", 32'(outB_valid), 32'h1);
    check("bp_B_data", outB_data, 32'hB0);
    drive(1, 1, 32'hC0, 1, 0); #1;
    check("bp_B_blocked", 32'(in_ready), 32'h0);
    step();
    check("bp_B_hold", outB_data, 32'hB0);
    drive(1, 1, 32'hC0, 1, 1); step();
    check("bp_B_passthru", outB_data, 32'hC0);
    drive(0, 0, 32'h0, 1, 1); step();

    // Full streaming, no bubbles
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 32'(i), 1, 1); step();
      check("stream_data", outA_data, 32'(i));
      check("stream_valid", 32'(outA_valid), 32'h1);
    end
    drive(0, 0, 32'h0, 1, 1); step();

    // Simultaneous drain and load
    drive(1, 0, 32'h5, 0, 1); step();
    drive(1, 0, 32'h6, 1, 1); step();
    check("dl_valid", 32'(outA_valid), 32'h1);
    check("dl_data", outA_data, 32'h6);
    drive(0, 0, 32'h0, 1, 1); step();

    // Reset mid-transfer, checked before any clock edge
    drive(1, 0, 32'hDEADBEEF, 0, 0); step();
    check("pre_rst_data", outA_data, 32'hDEADBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_outA_valid", 32'(outA_valid), 32'h0);
    check("rst_outA_data", outA_data, 32'h0);
`ifdef DEMUX_CNT_EN
    check("rst_cntA", 32'(cntA), 32'h0);
`endif
    drive(0, 0, 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs();

    // Randomized traffic with a producer that holds until accepted
    pend_v = 0; pend_s = 0; pend_d = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pend_v || last_accept) begin
        pend_v = ($urandom_range(0, 3) != 0);
        pend_s = 1'($urandom_range(0, 1));
        pend_d = $urandom;
      end
      drive(pend_v, pend_s, pend_d,
            $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
      last_accept = 0;
      step();
    end

`ifdef DEMUX_CNT_EN
    // Counter wrap on A with B untouched
    drive(0, 0, 32'h0, 1, 1); step();
    while ((exp_cnt_a & 32'hFFFF) != 32'hFFFF) begin
      drive(1, 0, 32'(exp_cnt_a), 1, 0);
      #1;
      last_accept = 0;
      if (qa.size() != 0) begin void'(qa.pop_front()); exp_cnt_a++; end
      qa.push_back(in_data);
      @(posedge clk); #1;
    end
    drive(0, 0, 32'h0, 1, 0); #1;
    check("wrap_pre", 32'(cntA), 32'hFFFF);
    begin
      logic [15:0] cntb_before;
      cntb_before = 16'(exp_cnt_b);
      step();
      check("wrap_cntA", 32'(cntA), 32'h0);
      check("wrap_cntB", 32'(cntB), 32'(cntb_before));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux32_1to2_buf.md
# demux32_1to2_buf

Registered 1-to-2 demultiplexer for 32-bit datapath words, the distributing counterpart of the 2-to-1 word select used across the multicycle datapath. One producer presents a word with a select bit over a valid/ready handshake. The block steers the word into a one-entry holding slot for output A (select=0) or output B (select=1). Each output drains independently under its own valid/ready handshake. It sits between a single result source (ALU/memory data register) and two consumers (e.g. register-file write port and I/O write port).

## Interface
- WIDTH, 32, data word width
- CNT_W, 16, transfer counter width (used only with the counter feature)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low (already decided)
- in_valid  in  1  producer presents word
- in_ready  out  1  block accepts word this cycle
- select  in  1  0 → output A, 1 → output B; sampled with in_data
- in_data  in  WIDTH  word
- outA_valid  out  1  slot A holds a word
- outA_ready  in  1  consumer A takes word
- outA_data  out  WIDTH  slot A word
- outB_valid / outB_ready / outB_data  as A, for slot B
- cntA, cntB  out  CNT_W  words delivered per output (only with DEMUX_CNT_EN)

## Operation
- Each slot has two states, EMPTY or FULL. outX_valid = (state==FULL).
- Transitions per slot X:
  - Load: in_valid && in_ready && select routes to X.
  - Drain: outX_valid && outX_ready.
  - EMPTY + load → FULL, and outX_data <= in_data.
  - FULL + drain, no load → EMPTY.
  - FULL + drain + load on the same cycle → stays FULL with the new data (pass-through, no bubble).
  - FULL + no drain → hold; data stays stable.
- in_ready is combinational: in_ready = slot[select] EMPTY || slot[select] draining this cycle. It does not depend on the unselected slot.
- A full B never blocks a transfer to A, and vice versa. Ordering is preserved per output only; A and B words may retire out of order.
- in_data and select are don't-care when in_valid=0.
- in_valid && !in_ready: nothing is loaded. The producer must hold in_valid, select and in_data stable until accepted.
- Once asserted, outX_valid stays high until the drain. outX_data is stable while outX_valid && !outX_ready.

## Timing
- Latency: 1 cycle. A word accepted at edge N appears on outX_* after edge N.
- Throughput: 1 word/cycle per output when the consumer holds ready=1.
- Reset (rst_n=0, any time, including mid-transfer):
  - both slots EMPTY, outA_valid=outB_valid=0
  - outA_data=outB_data=0, cntA=cntB=0
  - any held word is discarded
  - in_ready=1 is permitted during reset but no load occurs
- First accept is possible on the first rising edge after rst_n deasserts.
- Both outputs may drain on the same edge. At most one load per edge.

## Configuration
- DEMUX_CNT_EN defined:
  - cntA/cntB ports exist.
  - Each counter increments by 1 on its slot's drain handshake.
  - Counters wrap modulo 2^CNT_W (0xFFFF → 0x0000 at default).
- DEMUX_CNT_EN undefined:
  - cntA/cntB ports and counter registers are absent.
  - All other behaviour is identical.

## Structure
- Package demux_pkg holds:
  - WIDTH_DEF = 32 and CNT_W_DEF = 16
  - channel enum: CH_A = 1'b0, CH_B = 1'b1
- Sub-module demux_slot: one-entry holding register with load/drain, the optional counter, and a registered valid. It is instantiated twice (A, B).
- The top level holds only the select steering and in_ready generation.

## Test plan
- Reset mid-transfer: slot A FULL with 0xDEADBEEF, pulse rst_n low → outA_valid=0, outA_data=0, cntA=0, with no clock edge needed.
- Steering: send 0x11111111 (select=0) then 0x22222222 (select=1) with both readies high → outA_data=0x11111111 one cycle after accept, outB_data=0x22222222 the following cycle.
- Independent backpressure:
  - hold outB_ready=0; send 0xB0 (select=1), then 0xA0 (select=0) → A delivers 0xA0 while outB_valid stays 1 with stable 0xB0
  - a further select=1 word sees in_ready=0
- Full streaming: 8 consecutive select=0 words 0..7 with outA_ready=1 → in_ready stays 1 and outputs 0..7 in order on 8 consecutive cycles, no bubble.
- Simultaneous drain+load: slot A FULL with 0x5, outA_ready=1 and new select=0 word 0x6 on the same edge → outA_valid stays 1, outA_data=0x6.
- DEMUX_CNT_EN: preload via 0xFFFF drains on A → cntA=0xFFFF; one more drain → cntA=0x0000, cntB unchanged.
